// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Multiplexed 7-segment scanner with per-digit DP, leading-zero
//            blanking, PWM brightness, ghost gap and frame-atomic data update.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int NUM_DIG  = 6,
  parameter int SCAN_DIV = 50000,
  parameter int BRIGHT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [4*NUM_DIG-1:0] i_val,
  input  logic [NUM_DIG-1:0]   i_dp,
  input  logic                 i_blank_lz,
  input  logic [BRIGHT_W-1:0]  i_bright,
  output logic [NUM_DIG-1:0]   o_seg_enb,
  output logic [6:0]           o_seg,
  output logic                 o_seg_dp,
  output logic                 o_frame
);

  localparam int c_sw   = $clog2(SCAN_DIV);
  localparam int c_tw   = c_sw + 1;
  localparam int c_dw   = $clog2(NUM_DIG);
  localparam int c_step = SCAN_DIV >> BRIGHT_W;

  localparam logic [c_sw-1:0]     c_slot_last   = c_sw'(SCAN_DIV - 1);
  localparam logic [c_dw-1:0]     c_dig_last    = c_dw'(NUM_DIG - 1);
  localparam logic [BRIGHT_W-1:0] c_bright_full = '1;

  logic [c_sw-1:0]      r_slot_cnt;
  logic [c_dw-1:0]      r_dig_idx;
  logic [4*NUM_DIG-1:0] r_pend_val;
  logic [NUM_DIG-1:0]   r_pend_dp;
  logic                 r_pend;
  logic [4*NUM_DIG-1:0] r_disp_val;
  logic [NUM_DIG-1:0]   r_disp_dp;
  logic [c_tw-1:0]      r_thr;
  logic                 r_full;

  logic                 w_slot_wrap;
  logic                 w_boundary;
  logic [c_tw-1:0]      w_thr;
  logic                 w_en;
  logic [NUM_DIG-1:0]   w_onehot;
  logic [3:0]           w_nib;
  logic                 w_dp;
  logic                 w_lz;
  logic                 w_upper_zero;

  // Segment order {a,b,c,d,e,f,g}, segment a in bit 6.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h7E;
      4'h1: g = 7'h30;
      4'h2: g = 7'h6D;
      4'h3: g = 7'h79;
      4'h4: g = 7'h33;
      4'h5: g = 7'h5B;
      4'h6: g = 7'h5F;
      4'h7: g = 7'h70;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h7B;
      4'hA: g = 7'h77;
      4'hB: g = 7'h1F;
      4'hC: g = 7'h4E;
      4'hD: g = 7'h3D;
      4'hE: g = 7'h4F;
      default: g = 7'h47;
    endcase
    return g;
  endfunction

  assign w_slot_wrap = (r_slot_cnt == c_slot_last);
  assign w_boundary  = w_slot_wrap && (r_dig_idx == c_dig_last);
  assign w_thr       = c_tw'(i_bright) * c_tw'(c_step);
  assign w_onehot    = NUM_DIG'(1) << r_dig_idx;

  // Slot 0 is always dark so the previous digit's segments never ghost.
  assign w_en = (r_slot_cnt != '0) && (({1'b0, r_slot_cnt} < r_thr) || r_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_cnt <= '0;
      r_dig_idx  <= '0;
    end else if (w_slot_wrap) begin
      r_slot_cnt <= '0;
      r_dig_idx  <= (r_dig_idx == c_dig_last) ? '0 : r_dig_idx + c_dw'(1);
    end else begin
      r_slot_cnt <= r_slot_cnt + c_sw'(1);
    end
  end

  // Brightness is latched once per slot so a change never chops a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_thr  <= '0;
      r_full <= 1'b0;
    end else if (r_slot_cnt == '0) begin
      r_thr  <= w_thr;
      r_full <= (i_bright == c_bright_full);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend     <= 1'b0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
    end else if (w_boundary) begin
      if (i_load) begin
        r_disp_val <= i_val;
        r_disp_dp  <= i_dp;
      end else if (r_pend) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
      end
      r_pend <= 1'b0;
    end else if (i_load) begin
      r_pend_val <= i_val;
      r_pend_dp  <= i_dp;
      r_pend     <= 1'b1;
    end
  end

  // Select current digit and decide whether it is a leading zero.
  always_comb begin
    w_nib        = 4'h0;
    w_dp         = 1'b0;
    w_lz         = 1'b0;
    w_upper_zero = 1'b1;
    for (int k = NUM_DIG - 1; k >= 0; k--) begin
      w_upper_zero = w_upper_zero & (r_disp_val[4*k +: 4] == 4'h0);
      if (r_dig_idx == c_dw'(k)) begin
        w_nib = r_disp_val[4*k +: 4];
        w_dp  = r_disp_dp[k];
        w_lz  = (k != 0) && w_upper_zero;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_seg_enb <= '0;
      o_seg     <= '0;
      o_seg_dp  <= 1'b0;
      o_frame   <= 1'b0;
    end else begin
      o_seg_enb <= w_en ? w_onehot : '0;
      o_seg     <= (i_blank_lz && w_lz) ? 7'h00 : glyph(w_nib);
      o_seg_dp  <= w_dp;
      o_frame   <= w_boundary;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Scoreboard bench for seg_scan_ctrl against a cycle-count model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;
  localparam int ND    = 4;
  localparam int SD    = 32;
  localparam int BW    = 4;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_load = 1'b0;
  logic [15:0] i_val = '0;
  logic [3:0]  i_dp = '0;
  logic        i_blank_lz = 1'b0;
  logic [3:0]  i_bright = '0;
  logic [3:0]  o_seg_enb;
  logic [6:0]  o_seg;
  logic        o_seg_dp;
  logic        o_frame;

  typedef struct packed {
    logic [3:0] enb;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: position in scan is simply cycles since reset release.
  int          m_t = 0;
  logic [15:0] m_disp = '0, m_latest = '0;
  logic [3:0]  m_disp_dp = '0, m_latest_dp = '0;
  bit          m_have = 0;
  int          m_thr = 0;
  bit          m_full = 0;
  bit          m_primed = 0;

  // Segment order {a,b,c,d,e,f,g}, segment a in bit 6.
  logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seg_scan_ctrl #(.NUM_DIG(ND), .SCAN_DIV(SD), .BRIGHT_W(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_load    (i_load),
    .i_val     (i_val),
    .i_dp      (i_dp),
    .i_blank_lz(i_blank_lz),
    .i_bright  (i_bright),
    .o_seg_enb (o_seg_enb),
    .o_seg     (o_seg),
    .o_seg_dp  (o_seg_dp),
    .o_frame   (o_frame)
  );

  initial forever #5 clk = ~clk;

  task automatic check_zero(input string name);
    n_checks++;
    if (o_seg_enb !== 4'h0 || o_seg !== 7'h00 || o_seg_dp !== 1'b0 || o_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL %s t=%0t got enb=%b seg=%h dp=%b frame=%b, required all zero",
               name, $time, o_seg_enb, o_seg, o_seg_dp, o_frame);
    end
  endtask

  // Reference model: one expected output word per active clock edge.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_disp = '0; m_latest = '0; m_disp_dp = '0; m_latest_dp = '0;
      m_have = 0; m_thr = 0; m_full = 0; m_primed = 0;
    end else begin
      int         slot, dig;
      logic [3:0] nib;
      exp_t       e;
      slot = m_t % SD;
      dig  = (m_t / SD) % ND;
      nib  = m_disp[4*dig +: 4];
      e.enb   = (slot >= 1 && (slot < m_thr || m_full)) ? 4'(1 << dig) : 4'h0;
      e.seg   = (i_blank_lz && dig > 0 && (m_disp >> (4*dig)) == 16'h0) ? 7'h00 : glyph_tab[nib];
      e.dp    = m_disp_dp[dig];
      e.frame = (slot == SD - 1) && (dig == ND - 1);
      sb.push_back(e);
      m_primed = 1;
      if (slot == 0) begin
        m_thr  = int'(i_bright) * (SD / 16);
        m_full = (i_bright == 4'hF);
      end
      if (i_load) begin
        m_latest = i_val; m_latest_dp = i_dp; m_have = 1;
      end
      if (e.frame && m_have) begin
        m_disp = m_latest; m_disp_dp = m_latest_dp;
      end
      m_t++;
    end
  end

  // Monitor: compares every cycle's registered outputs away from the edge.
  initial forever begin
    @(negedge clk);
    if (rst || !m_primed) begin
      check_zero("reset_idle");
    end else if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t no expected word for DUT output", $time);
    end else begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if ({o_seg_enb, o_seg, o_seg_dp, o_frame} !== e) begin
        n_fail++;
        $display("FAIL scan t=%0t got enb=%b seg=%h dp=%b frame=%b, required enb=%b seg=%h dp=%b frame=%b",
                 $time, o_seg_enb, o_seg, o_seg_dp, o_frame, e.enb, e.seg, e.dp, e.frame);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    i_val  = v;
    i_dp   = dp;
    i_load = 1'b1;
    step(1);
    i_load = 1'b0;
  endtask

  // Advance until the next edge will process frame position ph.
  task automatic wait_phase(input int ph, input string tag);
    int n = 0;
    while ((m_t % FRAME) != ph && n < 2 * FRAME) begin
      step(1);
      n++;
    end
    if ((m_t % FRAME) != ph) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_%s timeout at position %0d, required %0d", tag, m_t % FRAME, ph);
    end
  endtask

  initial begin
    step(3);
    rst = 1'b0;

    // Full brightness, digit 2 DP.
    i_bright = 4'hF;
    load(16'h1234, 4'b0100);
    step(3 * FRAME);

    // Leading-zero blanking on and off.
    load(16'h0050, 4'b0000);
    i_blank_lz = 1'b1;
    step(2 * FRAME);
    i_blank_lz = 1'b0;
    step(FRAME);

    // Partial and zero brightness.
    i_bright = 4'd4;
    step(FRAME);
    i_bright = 4'd0;
    step(FRAME);
    i_bright = 4'hF;

    // Mid-frame load held until boundary; load on the boundary cycle.
    wait_phase(SD + 10, "mid_frame");
    load(16'hABCD, 4'b1001);
    step(2 * FRAME);
    wait_phase(FRAME - 1, "boundary");
    load(16'h9876, 4'b0010);
    step(2 * FRAME);

    // Two loads in a frame: only the second one ever shows.
    wait_phase(10, "first_load");
    load(16'h1111, 4'b0001);
    wait_phase(60, "second_load");
    load(16'h2222, 4'b1000);
    step(2 * FRAME);

    // Asynchronous reset at slot 17 of digit 2.
    wait_phase(2 * SD + 17, "async_reset");
    rst = 1'b1;
    sb.delete();
    m_primed = 0;
    #1;
    check_zero("async_reset");
    step(3);
    rst = 1'b0;
    step(2 * FRAME);

    // Randomised traffic.
    repeat (30 * FRAME) begin
      i_load = ($urandom_range(0, 39) == 0);
      i_val  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      i_dp   = 4'($urandom);
      if ($urandom_range(0, 99) == 0) i_bright = 4'($urandom);
      if ($urandom_range(0, 149) == 0) i_blank_lz = ~i_blank_lz;
      step(1);
    end
    i_load = 1'b0;
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
